ddr_to_rgb: RTL and testbench

//  Read side of the frame buffer: fetches one stored frame from DDR through an MCB read port
//  and emits it as an AXI-Stream pixel stream (tuser=SOF, tlast=EOL) toward the HDMI TX path.

---
 rtl/ddr_to_rgb_pkg.sv | 26 ++
 rtl/ddr_to_rgb_cmd_gen.sv | 72 +++++++
 rtl/ddr_to_rgb.sv | 175 +++++++++++++++++
 tb/tb_ddr_to_rgb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_to_rgb_pkg.sv
// Shared definitions for the frame-buffer read path (DDR -> RGB stream).
// MCB command codes, FSM states and default frame geometry.
package ddr_to_rgb_pkg;

    localparam logic [2:0] MCB_CMD_WRITE = 3'b000;
    localparam logic [2:0] MCB_CMD_READ  = 3'b001;

    localparam int DEF_H_PIXELS = 1024;
    localparam int DEF_V_LINES  = 768;

    localparam int FLUSH_EMPTY_CYCLES = 8;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } rd_state_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ddr_to_rgb_cmd_gen.sv
// Burst address/count generator with read-FIFO credit tracking.
// Issues read bursts only while the MCB read FIFO has room for them.
module ddr_rd_cmd_gen
    import ddr_to_rgb_pkg::*;
#(
    parameter int DDR_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 30,
    parameter int BURST_LEN      = 32,
    parameter int RD_FIFO_DEPTH  = 64,
    parameter int H_PIXELS       = DEF_H_PIXELS,
    parameter int V_LINES        = DEF_V_LINES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic                  i_run,
    input  logic                  i_cmd_full,
    input  logic                  i_pop,
    output logic                  o_cmd_en,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr
);

    localparam int BYTES       = DDR_DATA_WIDTH / 8;
    localparam int FRAME_WORDS = H_PIXELS * V_LINES;
    localparam int BURSTS      = FRAME_WORDS / BURST_LEN;
    localparam int BW          = clog2_min1(BURSTS + 1);
    localparam int OW          = clog2_min1(RD_FIFO_DEPTH + BURST_LEN + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN * BYTES);
    localparam logic [OW-1:0]         BL_W      = OW'(BURST_LEN);
    localparam logic [OW-1:0]         DEPTH_W   = OW'(RD_FIFO_DEPTH);
    localparam logic [BW-1:0]         BURSTS_W  = BW'(BURSTS);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BW-1:0]         r_bursts_left;
    logic [OW-1:0]         r_outstanding;
    logic                  w_credit_ok;
    logic                  w_cmd_en;
    logic [OW-1:0]         w_add;
    logic [OW-1:0]         w_sub;

    assign w_credit_ok = (r_outstanding + BL_W) <= DEPTH_W;
    assign w_cmd_en    = i_run && !i_cmd_full
                      && (r_bursts_left != '0) && w_credit_ok;

    assign w_add = w_cmd_en ? BL_W : '0;
    assign w_sub = i_pop ? OW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_bursts_left <= '0;
            r_outstanding <= '0;
        end else if (i_clear) begin
            r_addr        <= i_base;
            r_bursts_left <= BURSTS_W;
            r_outstanding <= '0;
        end else begin
            if (w_cmd_en) begin
                r_addr        <= r_addr + ADDR_STEP;
                r_bursts_left <= r_bursts_left - BW'(1);
            end
            // issue and pop in the same cycle net out here
            r_outstanding <= r_outstanding + w_add - w_sub;
        end
    end

    assign o_cmd_en   = w_cmd_en;
    assign o_cmd_addr = r_addr;

endmodule

// File: rtl/ddr_to_rgb.sv
// Frame-buffer reader: fetches one frame from an MCB read port and
// emits it as an AXI-Stream pixel stream (tuser=SOF, tlast=EOL).
module ddr_to_rgb
    import ddr_to_rgb_pkg::*;
#(
    parameter int RGB_WIDTH      = 24,
    parameter int DDR_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 30,
    parameter int BURST_LEN      = 32,
    parameter int RD_FIFO_DEPTH  = 64,
    parameter int H_PIXELS       = DEF_H_PIXELS,
    parameter int V_LINES        = DEF_V_LINES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     frame_base_addr,
    input  logic                      start,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      cmd_en,
    output logic [2:0]                cmd_instr,
    output logic [5:0]                cmd_bl,
    output logic [ADDR_WIDTH-1:0]     cmd_byte_addr,
    input  logic                      cmd_full,
    output logic                      rd_en,
    input  logic [DDR_DATA_WIDTH-1:0] rd_data,
    input  logic                      rd_empty,
    output logic [RGB_WIDTH-1:0]      m_frame_axis_tdata,
    output logic                      m_frame_axis_tvalid,
    input  logic                      m_frame_axis_tready,
    output logic                      m_frame_axis_tuser,
    output logic                      m_frame_axis_tlast
);

    localparam int FRAME_WORDS = H_PIXELS * V_LINES;
    localparam int XW          = clog2_min1(H_PIXELS);
    localparam int YW          = clog2_min1(V_LINES);
    localparam int PW          = clog2_min1(FRAME_WORDS + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_LINES - 1);
    localparam logic [PW-1:0] FRAME_W  = PW'(FRAME_WORDS);
    localparam logic [2:0]    EMPTY_TH = 3'(FLUSH_EMPTY_CYCLES - 1);

    rd_state_t r_state;
    rd_state_t w_next;

    logic [2:0]           r_empty_cnt;
    logic                 r_flush_en;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [PW-1:0]        r_pops_left;
    logic [RGB_WIDTH-1:0] r_tdata;
    logic                 r_tvalid;
    logic                 r_tuser;
    logic                 r_tlast;
    logic                 r_tend;

    logic w_accept_start;
    logic w_fire;
    logic w_last_hs;
    logic w_run_pop;
    logic w_flush_pop;
    logic w_in_run;

    assign w_in_run       = (r_state == ST_RUN);
    assign w_accept_start = (r_state == ST_IDLE) && start;
    assign w_fire         = r_tvalid && m_frame_axis_tready;
    assign w_last_hs      = w_fire && r_tend;

    assign w_run_pop = w_in_run && !rd_empty
                    && (!r_tvalid || m_frame_axis_tready)
                    && (r_pops_left != '0);

    // flush pops start one cycle after reset release so rd_en stays low in reset
    assign w_flush_pop = (r_state == ST_FLUSH) && r_flush_en && !rd_empty;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_FLUSH: if (rd_empty && (r_empty_cnt == EMPTY_TH)) w_next = ST_IDLE;
            ST_IDLE:  if (start) w_next = ST_RUN;
            ST_RUN:   if (w_last_hs) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FLUSH;
            r_empty_cnt <= '0;
            r_flush_en  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_flush_en <= 1'b1;
            if ((r_state == ST_FLUSH) && rd_empty) begin
                r_empty_cnt <= r_empty_cnt + 3'd1;
            end else begin
                r_empty_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tuser     <= 1'b0;
            r_tlast     <= 1'b0;
            r_tend      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_pops_left <= '0;
        end else if (w_accept_start) begin
            r_tvalid    <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_pops_left <= FRAME_W;
        end else if (w_run_pop) begin
            r_tdata     <= rd_data[RGB_WIDTH-1:0];
            r_tvalid    <= 1'b1;
            r_tuser     <= (r_x == '0) && (r_y == '0);
            r_tlast     <= (r_x == X_LAST);
            r_tend      <= (r_pops_left == PW'(1));
            r_pops_left <= r_pops_left - PW'(1);
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end else if (w_fire) begin
            r_tvalid <= 1'b0;
        end
    end

    ddr_rd_cmd_gen #(
        .DDR_DATA_WIDTH (DDR_DATA_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .BURST_LEN      (BURST_LEN),
        .RD_FIFO_DEPTH  (RD_FIFO_DEPTH),
        .H_PIXELS       (H_PIXELS),
        .V_LINES        (V_LINES)
    ) u_cmd_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_accept_start),
        .i_base     (frame_base_addr),
        .i_run      (w_in_run),
        .i_cmd_full (cmd_full),
        .i_pop      (w_run_pop),
        .o_cmd_en   (cmd_en),
        .o_cmd_addr (cmd_byte_addr)
    );

    generate
        if (DDR_DATA_WIDTH > RGB_WIDTH) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = ^rd_data[DDR_DATA_WIDTH-1:RGB_WIDTH];
        end
    endgenerate

    assign rd_en      = w_run_pop || w_flush_pop;
    assign busy       = w_in_run || ((r_state == ST_FLUSH) && r_flush_en);
    assign frame_done = (r_state == ST_DONE);
    assign cmd_instr  = MCB_CMD_READ;
    assign cmd_bl     = 6'(BURST_LEN - 1);

    assign m_frame_axis_tdata  = r_tdata;
    assign m_frame_axis_tvalid = r_tvalid;
    assign m_frame_axis_tuser  = r_tuser;
    assign m_frame_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_ddr_to_rgb.sv
// Bench for ddr_to_rgb: MCB read model returning word=addr, pixel scoreboard,
// table of frame scenarios plus reset/flush sequences.
module tb_ddr_to_rgb;

    localparam int H   = 8;
    localparam int V   = 2;
    localparam int BL  = 4;
    localparam int DEP = 8;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int RW  = 24;
    localparam int NPIX = H * V;
    localparam int NBUR = NPIX / BL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] frame_base_addr = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          frame_done;
    logic          cmd_en;
    logic [2:0]    cmd_instr;
    logic [5:0]    cmd_bl;
    logic [AW-1:0] cmd_byte_addr;
    logic          cmd_full = 1'b0;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          rd_empty = 1'b1;
    logic [RW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tuser;
    logic          tlast;

    ddr_to_rgb #(
        .RGB_WIDTH(RW), .DDR_DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .BURST_LEN(BL), .RD_FIFO_DEPTH(DEP), .H_PIXELS(H), .V_LINES(V)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_base_addr(frame_base_addr),
        .start(start), .busy(busy), .frame_done(frame_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .m_frame_axis_tdata(tdata), .m_frame_axis_tvalid(tvalid),
        .m_frame_axis_tready(tready), .m_frame_axis_tuser(tuser),
        .m_frame_axis_tlast(tlast)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0]   mfifo[$];
    logic [AW-1:0] exp_cmd[$];
    logic [25:0]   exp_pix[$];
    int out_req = 0, out_pop = 0, peak = 0;
    int full_viol = 0, hold_viol = 0, done_cnt = 0;
    int rmode = 0, full_left = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // MCB model: commands and pops seen at the edge are applied just after it
    always begin
        logic          s_cmd, s_pop, s_full;
        logic [AW-1:0] s_addr;
        @(negedge clk);
        s_cmd = cmd_en; s_pop = rd_en; s_full = cmd_full; s_addr = cmd_byte_addr;
        if (rst_n && s_cmd) begin
            if (s_full) full_viol++;
            if (exp_cmd.size() == 0) chk("unexpected_cmd", 64'(s_addr), 64'hFFFF_FFFF);
            else chk("cmd_addr", 64'(s_addr), 64'(exp_cmd.pop_front()));
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (s_pop && mfifo.size() > 0) begin
                void'(mfifo.pop_front());
                out_pop++;
            end
            if (s_cmd) begin
                for (int k = 0; k < BL; k++) mfifo.push_back(32'(s_addr + AW'(4 * k)));
                out_req += BL;
            end
            if (out_req - out_pop > peak) peak = out_req - out_pop;
        end
        rd_empty = (mfifo.size() == 0);
        rd_data  = (mfifo.size() != 0) ? mfifo[0] : '0;
    end

    always begin
        @(posedge clk);
        #2;
        case (rmode)
            0: tready = 1'b1;
            1: tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
        if (full_left > 0) begin
            cmd_full = 1'b1;
            full_left--;
        end else begin
            cmd_full = 1'b0;
        end
    end

    logic          hold_pend = 1'b0;
    logic [25:0]   hold_val;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (frame_done) done_cnt++;
            if (hold_pend && (!tvalid || {tuser, tlast, tdata} != hold_val)) hold_viol++;
            hold_pend = tvalid && !tready;
            hold_val  = {tuser, tlast, tdata};
            if (tvalid && tready) begin
                if (exp_pix.size() == 0) chk("unexpected_pixel", 64'({tuser, tlast, tdata}), 64'h3FF_FFFF);
                else chk("pixel{user,last,data}", 64'({tuser, tlast, tdata}), 64'(exp_pix.pop_front()));
            end
        end
    end

    typedef struct {
        logic [AW-1:0] base;
        int            rmode;
        int            full_len;
        int            stall;
        bit            restart;
        int            min_peak;
    } vec_t;

    task automatic run_frame(input vec_t v);
        logic [AW-1:0] a;
        int n;
        @(negedge clk);
        out_req = 0; out_pop = 0; peak = 0;
        full_viol = 0; hold_viol = 0; done_cnt = 0;
        for (int i = 0; i < NPIX; i++) begin
            a = v.base + AW'(4 * i);
            exp_pix.push_back({1'(i == 0), 1'((i % H) == H - 1), a[RW-1:0]});
        end
        for (int b = 0; b < NBUR; b++) exp_cmd.push_back(v.base + AW'(16 * b));
        rmode = (v.stall > 0) ? 2 : v.rmode;
        @(posedge clk); #1;
        frame_base_addr = v.base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; frame_base_addr = 30'h0ABC_DE0;
        if (v.full_len > 0) begin
            repeat (3) @(posedge clk);
            #1 full_left = v.full_len;
        end
        if (v.restart) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        if (v.stall > 0) begin
            repeat (v.stall) @(posedge clk);
            #1 rmode = v.rmode;
        end
        n = 0;
        while (done_cnt == 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("frame_done_count", 64'(done_cnt), 64'd1);
        chk("pixels_left", 64'(exp_pix.size()), 64'd0);
        chk("cmds_left", 64'(exp_cmd.size()), 64'd0);
        chk("cmd_en_while_full", 64'(full_viol), 64'd0);
        chk("hold_stable_viol", 64'(hold_viol), 64'd0);
        chk("peak_le_depth", 64'(peak <= DEP), 64'd1);
        chk("peak_ge_min", 64'(peak >= v.min_peak), 64'd1);
        chk("busy_after_frame", 64'(busy), 64'd0);
        exp_pix.delete();
        exp_cmd.delete();
    endtask

    vec_t vecs[5];
    vec_t hv;

    initial begin
        vecs[0] = '{30'h100,        0, 0,  0,  1'b0, 0};
        vecs[1] = '{30'h100,        1, 0,  0,  1'b1, 0};
        vecs[2] = '{30'h200,        0, 20, 0,  1'b0, 0};
        vecs[3] = '{30'h3FFF_FFF0,  1, 0,  0,  1'b0, 0};
        vecs[4] = '{30'h400,        0, 0,  40, 1'b0, DEP - BL + 1};

        rmode = 2;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({tvalid, tuser, tlast, tdata, cmd_en, rd_en, frame_done}), 64'd0);
        chk("reset_cmd_instr", 64'(cmd_instr), 64'd1);
        chk("reset_cmd_bl", 64'(cmd_bl), 64'(BL - 1));
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("flush_busy_7", 64'(busy), 64'd1);
        @(posedge clk);
        #1 chk("flush_busy_8", 64'(busy), 64'd0);
        chk("idle_outputs", 64'({tvalid, cmd_en, rd_en, frame_done}), 64'd0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // abort a stalled frame by reset with stale words in the MCB FIFO
        rmode = 2;
        for (int b = 0; b < NBUR; b++) exp_cmd.push_back(30'h500 + AW'(16 * b));
        @(posedge clk); #1;
        frame_base_addr = 30'h500; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({tvalid, cmd_en, rd_en, frame_done, busy}), 64'd0);
        mfifo.delete();
        for (int k = 0; k < 10; k++) mfifo.push_back(32'h00BA_D000 + 32'(k));
        exp_cmd.delete();
        exp_pix.delete();
        repeat (2) @(posedge clk);
        #1;
        out_pop = 0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        begin
            int n;
            n = 0;
            while (busy && n < 100) begin
                @(posedge clk);
                #1 n++;
            end
        end
        chk("flush_popped", 64'(out_pop), 64'd10);
        chk("flush_fifo_empty", 64'(mfifo.size()), 64'd0);
        chk("flush_done_idle", 64'(busy), 64'd0);

        hv = '{30'h600, 0, 0, 0, 1'b0, 0};
        run_frame(hv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
